// File: rtl/pulse_width_meter_if.sv
// Host-side handshake of the pulse width meter: arm/cancel requests in, result and status out.
interface pulse_width_meter_if #(
  parameter int COUNTER_BITS = 8
);
  logic                    start;
  logic                    abort;
  logic [COUNTER_BITS-1:0] count;
  logic                    valid;
  logic                    overflow;
  logic                    busy;

  modport master (
    output start, abort,
    input  count, valid, overflow, busy
  );

  modport slave (
    input  start, abort,
    output count, valid, overflow, busy
  );
endinterface

// File: rtl/pulse_width_meter.sv
// Measures the high time of an asynchronous input in clk_en ticks and reports it
// with a one-clk valid strobe; saturates at the counter maximum with an overflow flag.
module pulse_width_meter #(
  parameter int COUNTER_BITS = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 en,
  input  logic                 sig_in,
  pulse_width_meter_if.slave   host
);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;

  localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
  localparam logic [COUNTER_BITS-1:0] CNT_ZERO = '0;
  localparam logic [COUNTER_BITS-1:0] CNT_ONE  = CNT_ZERO + 1'b1;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    s, s_prev;
  logic                    rise, tick, load_result;
  logic [COUNTER_BITS-1:0] counter;
  logic                    ovf;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev;
  assign tick = clk_en & en;

  // Synchroniser plus one extra flop for edge detection; only latency is added.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev <= s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (host.start) state_d = ARMED;
      ARMED:   if (host.abort) state_d = IDLE;
               else if (rise)  state_d = MEASURE;
      MEASURE: if (host.abort) state_d = IDLE;
               else if (!s)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    host.busy   = (state_q == ARMED) || (state_q == MEASURE);
    load_result = (state_q == DONE);
  end

  // A level already high at arm time never produces `rise`, so it is skipped
  // until the input has dropped and come back up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter <= CNT_ZERO;
      ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (host.abort) begin
            counter <= CNT_ZERO;
            ovf     <= 1'b0;
          end else if (rise) begin
            counter <= tick ? CNT_ONE : CNT_ZERO;
            ovf     <= 1'b0;
          end
        end
        MEASURE: begin
          if (host.abort) begin
            counter <= CNT_ZERO;
            ovf     <= 1'b0;
          end else if (s && tick) begin
            if (counter == CNT_MAX) ovf <= 1'b1;
            else                    counter <= counter + CNT_ONE;
          end
        end
        DONE: begin
          counter <= CNT_ZERO;
          ovf     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host.count    <= CNT_ZERO;
      host.overflow <= 1'b0;
      host.valid    <= 1'b0;
    end else begin
      host.valid <= load_result;
      if (load_result) begin
        host.count    <= counter;
        host.overflow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter: hand-computed widths, saturation, gating,
// abort, already-high input and asynchronous reset.
module tb_pulse_width_meter;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;
  logic en;
  logic sig_in;
  int   ce_mode;        // 0: every clk, 1: every 2nd clk, 2: never

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  int last_count = 0;
  int last_ovf = 0;

  pulse_width_meter_if #(.COUNTER_BITS(8)) bus ();

  pulse_width_meter #(.COUNTER_BITS(8), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .en     (en),
    .sig_in (sig_in),
    .host   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ce_mode)
      0:       clk_en = 1'b1;
      1:       clk_en = ~clk_en;
      default: clk_en = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      valid_cnt++;
      last_count = int'(bus.count);
      last_ovf   = int'(bus.overflow);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pulse(input int n);
    sig_in = 1'b1;
    repeat (n) step();
    sig_in = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int base);
    int seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (valid_cnt != base) begin
        seen = 1;
        break;
      end
      step();
    end
    check({tag, "_valid_seen"}, seen, 1);
  endtask

  task automatic measure(input string tag, input int width, input int exp_cnt, input int exp_ovf);
    int base = valid_cnt;
    arm();
    repeat (2) step();
    pulse(width);
    wait_valid(tag, base);
    check({tag, "_count"}, last_count, exp_cnt);
    check({tag, "_ovf"}, last_ovf, exp_ovf);
    repeat (3) step();
    check({tag, "_valid_pulses"}, valid_cnt - base, 1);
    check({tag, "_busy_after"}, int'(bus.busy), 0);
  endtask

  initial begin
    int base;
    reset = 1'b0; ce_mode = 0; clk_en = 1'b1; en = 1'b1; sig_in = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    #12;
    check("rst_count", int'(bus.count), 0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    check("rst_busy", int'(bus.busy), 0);
    reset = 1'b1;
    repeat (2) step();

    measure("plain", 7, 7, 0);

    ce_mode = 1; step();
    measure("div2", 20, 10, 0);
    ce_mode = 0; step();

    base = valid_cnt;
    arm();
    repeat (2) step();
    sig_in = 1'b1;
    repeat (4) step();
    en = 1'b0;
    repeat (4) step();
    en = 1'b1;
    repeat (4) step();
    sig_in = 1'b0;
    wait_valid("gate", base);
    check("gate_count", last_count, 8);

    ce_mode = 2; step();
    measure("zero", 1, 0, 0);
    ce_mode = 0; step();

    measure("exact_max", 255, 255, 0);
    measure("sat", 300, 255, 1);
    measure("after_sat", 5, 5, 0);

    step();
    bus.start = 1'b1; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_beats_abort_busy", int'(bus.busy), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_armed_busy", int'(bus.busy), 0);

    base = valid_cnt;
    sig_in = 1'b1;
    repeat (4) step();
    arm();
    repeat (10) step();
    check("high_at_arm_no_valid", valid_cnt - base, 0);
    check("high_at_arm_busy", int'(bus.busy), 1);
    sig_in = 1'b0;
    repeat (4) step();
    check("fall_in_armed_no_valid", valid_cnt - base, 0);
    pulse(4);
    wait_valid("fresh_rise", base);
    check("fresh_rise_count", last_count, 4);
    repeat (3) step();

    base = valid_cnt;
    arm();
    repeat (2) step();
    sig_in = 1'b1;
    repeat (5) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_meas_busy", int'(bus.busy), 0);
    sig_in = 1'b0;
    repeat (8) step();
    check("abort_no_valid", valid_cnt - base, 0);
    check("abort_count_kept", int'(bus.count), 4);

    arm();
    repeat (2) step();
    sig_in = 1'b1;
    repeat (4) step();
    check("pre_reset_busy", int'(bus.busy), 1);
    reset = 1'b0;
    #1;
    check("async_rst_count", int'(bus.count), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_valid", int'(bus.valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sig_in = 1'b0;
    repeat (4) step();
    measure("post_reset", 3, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
